// File: rtl/atmos_light_est.sv
// atmos_light_est: estimates atmospheric light A from a dark-channel stream.
// Per frame, the pixel with the largest dark-channel value is tracked (the first
// one wins on ties). The brightest RGB component of that pixel, clamped to
// [A_MIN, A_MAX], becomes the new A. If the frame's accepted-pixel count is not
// PIC_WIDTH*PIC_HEIGHT, the frame is rejected and A is held.
// Optional build macro ATMOS_LIGHT_IIR_EN: A is smoothed as
// (3*A + clamped + 2) >> 2 instead of being loaded directly.
module atmos_light_est #(
    parameter int          PIC_WIDTH  = 640,
    parameter int          PIC_HEIGHT = 480,
    parameter logic [7:0]  A_MIN      = 8'd100,
    parameter logic [7:0]  A_MAX      = 8'd240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pre_frame_vsync,
    input  logic        pre_frame_href,
    input  logic        pre_frame_clken,
    input  logic [7:0]  pre_dark,
    input  logic [23:0] pre_img,
    output logic [7:0]  post_A,
    output logic        post_A_valid,
    output logic        post_frame_err
);

    localparam logic [19:0] PIX_TOTAL = 20'(PIC_WIDTH * PIC_HEIGHT);

    typedef enum logic [1:0] {IDLE, ACCUM, CALC, OUT} state_t;

    state_t      state_q, state_d;
    logic        vsync_q, vsync_d;
    logic        armed_q, armed_d;
    logic [7:0]  dark_max_q, dark_max_d;
    logic [7:0]  cand_q, cand_d;
    logic [19:0] cnt_q, cnt_d;
    logic [7:0]  clamped_q, clamped_d;
    logic        bad_q, bad_d;
    logic [7:0]  pend_a_q, pend_a_d;
    logic        pend_vld_q, pend_vld_d;
    logic        pend_err_q, pend_err_d;
    logic [7:0]  post_a_q, post_a_d;
    logic        post_a_valid_q, post_a_valid_d;
    logic        post_frame_err_q, post_frame_err_d;

    logic        pix_ok;
    logic        vs_rise;
    logic        vs_fall;

    function automatic logic [7:0] max_rgb(input logic [23:0] rgb);
        logic [7:0] m;
        m = rgb[23:16];
        if (rgb[15:8] > m) m = rgb[15:8];
        if (rgb[7:0] > m)  m = rgb[7:0];
        return m;
    endfunction

    function automatic logic [7:0] clamp_a(input logic [7:0] v);
        if (v < A_MIN)      return A_MIN;
        else if (v > A_MAX) return A_MAX;
        else                return v;
    endfunction

`ifdef ATMOS_LIGHT_IIR_EN
    function automatic logic [7:0] iir_a(input logic [7:0] prev, input logic [7:0] cur);
        logic [9:0] acc;
        acc = {2'b00, prev} + {2'b00, prev} + {2'b00, prev} + {2'b00, cur} + 10'd2;
        return acc[9:2];
    endfunction
`endif

    assign pix_ok  = pre_frame_vsync & pre_frame_href & pre_frame_clken;
    // A rising edge only counts once vsync has been seen low since reset, so a
    // vsync already high when reset releases does not start a partial frame.
    assign vs_rise = pre_frame_vsync & ~vsync_q & armed_q;
    assign vs_fall = ~pre_frame_vsync & vsync_q;

    // Next-state and datapath logic for the frame FSM and output staging.
    always_comb begin
        state_d          = state_q;
        vsync_d          = pre_frame_vsync;
        armed_d          = armed_q | ~pre_frame_vsync;
        dark_max_d       = dark_max_q;
        cand_d           = cand_q;
        cnt_d            = cnt_q;
        clamped_d        = clamped_q;
        bad_d            = bad_q;
        pend_a_d         = pend_a_q;
        pend_vld_d       = 1'b0;
        pend_err_d       = 1'b0;
        post_a_d         = pend_vld_q ? pend_a_q : post_a_q;
        post_a_valid_d   = pend_vld_q;
        post_frame_err_d = pend_err_q;

        case (state_q)
            IDLE: begin
                if (vs_rise) begin
                    state_d    = ACCUM;
                    dark_max_d = 8'd0;
                    cand_d     = 8'd0;
                    cnt_d      = 20'd0;
                end
            end
            ACCUM: begin
                if (vs_fall) begin
                    state_d = CALC;
                end else if (pix_ok) begin
                    if (cnt_q != '1) cnt_d = cnt_q + 20'd1;
                    if (pre_dark > dark_max_q) begin
                        dark_max_d = pre_dark;
                        cand_d     = max_rgb(pre_img);
                    end
                end
            end
            CALC: begin
                clamped_d = clamp_a(cand_q);
                bad_d     = (cnt_q != PIX_TOTAL);
                state_d   = OUT;
            end
            OUT: begin
                if (bad_q) begin
                    pend_err_d = 1'b1;
                end else begin
                    pend_vld_d = 1'b1;
`ifdef ATMOS_LIGHT_IIR_EN
                    pend_a_d   = iir_a(post_a_q, clamped_q);
`else
                    pend_a_d   = clamped_q;
`endif
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset discards any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            vsync_q          <= 1'b0;
            armed_q          <= 1'b0;
            dark_max_q       <= 8'd0;
            cand_q           <= 8'd0;
            cnt_q            <= 20'd0;
            clamped_q        <= 8'd0;
            bad_q            <= 1'b0;
            pend_a_q         <= 8'd0;
            pend_vld_q       <= 1'b0;
            pend_err_q       <= 1'b0;
            post_a_q         <= A_MAX;
            post_a_valid_q   <= 1'b0;
            post_frame_err_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            vsync_q          <= vsync_d;
            armed_q          <= armed_d;
            dark_max_q       <= dark_max_d;
            cand_q           <= cand_d;
            cnt_q            <= cnt_d;
            clamped_q        <= clamped_d;
            bad_q            <= bad_d;
            pend_a_q         <= pend_a_d;
            pend_vld_q       <= pend_vld_d;
            pend_err_q       <= pend_err_d;
            post_a_q         <= post_a_d;
            post_a_valid_q   <= post_a_valid_d;
            post_frame_err_q <= post_frame_err_d;
        end
    end

    assign post_A         = post_a_q;
    assign post_A_valid   = post_a_valid_q;
    assign post_frame_err = post_frame_err_q;

endmodule
